// File: rtl/apb_rr_manager.sv
// apb_rr_manager: APB manager shared by ReqNum requesters with round-robin
// arbitration. A granted request is latched, then driven through the
// SETUP/ACCESS phases. Completion returns a one-cycle reqAck pulse with
// registered respData/respError.
//
// Handshake: a requester raises reqValid and holds it, with its request
// fields, until it sees its reqAck bit. A request dropped before grant is
// ignored. Fields that change after grant do not affect the latched
// transfer. The requester that was just acked is masked from arbitration
// in the completion cycle and in the ack cycle. This lets it drop reqValid
// in reaction to reqAck without being granted twice.
//
// Optional feature: define APB_RR_TIMEOUT_EN to end an ACCESS phase with an
// error after TimeoutCycles cycles of ready=0. Without the macro the manager
// waits for ready indefinitely.
//
// dbgState exposes the FSM state: 0 = IDLE, 1 = SETUP, 2 = ACCESS.
module apb_rr_manager #(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int PrphNum       = 4,
    parameter int ReqNum        = 2,
    parameter int TimeoutCycles = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [ReqNum-1:0]             reqValid,
    input  logic [ReqNum*AddrWidth-1:0]   reqAddr,
    input  logic [ReqNum-1:0]             reqWrite,
    input  logic [ReqNum*DataWidth-1:0]   reqWData,
    input  logic [ReqNum*DataWidth/8-1:0] reqStrb,
    input  logic [ReqNum*3-1:0]           reqProt,
    output logic [ReqNum-1:0]             reqAck,
    output logic [DataWidth-1:0]          respData,
    output logic                          respError,
    output logic [AddrWidth-1:0]          addr,
    output logic [2:0]                    prot,
    output logic [PrphNum-1:0]            selectors,
    output logic                          enable,
    output logic                          write,
    output logic [DataWidth-1:0]          wData,
    output logic [DataWidth/8-1:0]        strb,
    input  logic                          ready,
    input  logic [DataWidth-1:0]          rData,
    input  logic                          subError,
    output logic [1:0]                    dbgState
);

    localparam int GW = $clog2(ReqNum);
    localparam int PW = $clog2(PrphNum);
    localparam int SW = DataWidth / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [GW-1:0]         last_grant_q, last_grant_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [AddrWidth-1:0]  addr_q, addr_d;
    logic [2:0]            prot_q, prot_d;
    logic                  write_q, write_d;
    logic [DataWidth-1:0]  wdata_q, wdata_d;
    logic [SW-1:0]         strb_q, strb_d;
    logic [ReqNum-1:0]     ack_q, ack_d;
    logic [DataWidth-1:0]  resp_data_q, resp_data_d;
    logic                  resp_err_q, resp_err_d;

    logic [ReqNum-1:0]     cand;
    logic                  found;
    logic [GW-1:0]         pick;
    int                    idx;
    logic                  do_grant;
    logic                  timeout;

`ifdef APB_RR_TIMEOUT_EN
    localparam int TW = $clog2(TimeoutCycles + 1);
    logic [TW-1:0] tmo_q, tmo_d;

    // Count ACCESS cycles spent waiting; expire on the last allowed cycle.
    always_comb begin
        timeout = (state_q == ACCESS) && !ready && (tmo_q == TW'(TimeoutCycles - 1));
        tmo_d   = '0;
        if (state_q == ACCESS && !ready && !timeout) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        cand = reqValid & ~ack_q;
        if (state_q == ACCESS) begin
            cand[grant_q] = 1'b0;
        end
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 1; k <= ReqNum; k++) begin
            idx = int'(last_grant_q) + k;
            if (idx >= ReqNum) begin
                idx = idx - ReqNum;
            end
            if (!found && cand[idx[GW-1:0]]) begin
                found = 1'b1;
                pick  = idx[GW-1:0];
            end
        end
    end

    // Next-state logic: phase sequencing, grant latching and completion.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        prot_d       = prot_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        strb_d       = strb_q;
        ack_d        = '0;
        resp_data_d  = resp_data_q;
        resp_err_d   = 1'b0;
        do_grant     = 1'b0;

        case (state_q)
            IDLE: begin
                do_grant = found;
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (ready || timeout) begin
                    ack_d[grant_q] = 1'b1;
                    resp_data_d    = ready ? rData : '0;
                    resp_err_d     = ready ? subError : 1'b1;
                    state_d        = IDLE;
                    do_grant       = found;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_grant) begin
            state_d      = SETUP;
            grant_d      = pick;
            last_grant_d = pick;
            addr_d       = reqAddr[int'(pick)*AddrWidth +: AddrWidth];
            prot_d       = reqProt[int'(pick)*3 +: 3];
            write_d      = reqWrite[pick];
            wdata_d      = reqWData[int'(pick)*DataWidth +: DataWidth];
            // Reads never carry strobes, whatever the requester presents.
            strb_d       = reqWrite[pick] ? reqStrb[int'(pick)*SW +: SW] : '0;
        end
    end

    // State and datapath registers; reset aborts any transfer in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= GW'(ReqNum - 1);
            grant_q      <= '0;
            addr_q       <= '0;
            prot_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            strb_q       <= '0;
            ack_q        <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            prot_q       <= prot_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            strb_q       <= strb_d;
            ack_q        <= ack_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Peripheral select decodes the top address bits while a transfer is active.
    always_comb begin
        selectors = '0;
        if (state_q != IDLE) begin
            selectors[addr_q[AddrWidth-1 -: PW]] = 1'b1;
        end
    end

    assign enable    = (state_q == ACCESS);
    assign addr      = addr_q;
    assign prot      = prot_q;
    assign write     = write_q;
    assign wData     = wdata_q;
    assign strb      = strb_q;
    assign reqAck    = ack_q;
    assign respData  = resp_data_q;
    assign respError = resp_err_q;
    assign dbgState  = state_q;

endmodule

// File: tb/tb_apb_rr_manager.sv
// Directed testbench for apb_rr_manager with hand-computed expectations.
module tb_apb_rr_manager;

    logic        clk;
    logic        reset;
    logic [1:0]  reqValid;
    logic [63:0] reqAddr;
    logic [1:0]  reqWrite;
    logic [63:0] reqWData;
    logic [7:0]  reqStrb;
    logic [5:0]  reqProt;
    logic [1:0]  reqAck;
    logic [31:0] respData;
    logic        respError;
    logic [31:0] addr;
    logic [2:0]  prot;
    logic [3:0]  selectors;
    logic        enable;
    logic        write;
    logic [31:0] wData;
    logic [3:0]  strb;
    logic        ready;
    logic [31:0] rData;
    logic        subError;
    logic [1:0]  dbgState;

    int checks = 0;
    int errors = 0;

    apb_rr_manager #(
        .AddrWidth(32), .DataWidth(32), .PrphNum(4), .ReqNum(2), .TimeoutCycles(16)
    ) dut (
        .clk(clk), .reset(reset),
        .reqValid(reqValid), .reqAddr(reqAddr), .reqWrite(reqWrite),
        .reqWData(reqWData), .reqStrb(reqStrb), .reqProt(reqProt),
        .reqAck(reqAck), .respData(respData), .respError(respError),
        .addr(addr), .prot(prot), .selectors(selectors), .enable(enable),
        .write(write), .wData(wData), .strb(strb),
        .ready(ready), .rData(rData), .subError(subError),
        .dbgState(dbgState)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and sample 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [31:0] a, input logic w,
                           input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
        reqAddr[r*32 +: 32] = a;
        reqWrite[r]         = w;
        reqWData[r*32 +: 32] = d;
        reqStrb[r*4 +: 4]   = s;
        reqProt[r*3 +: 3]   = p;
        reqValid[r]         = 1'b1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_state"}, 64'(dbgState), 64'd0);
        check({tag, "_sel"}, 64'(selectors), 64'h0);
        check({tag, "_en"}, 64'(enable), 64'd0);
        check({tag, "_ack"}, 64'(reqAck), 64'h0);
        check({tag, "_err"}, 64'(respError), 64'd0);
    endtask

    initial begin
        int seen;
        reset = 1'b1; reqValid = '0; reqAddr = '0; reqWrite = '0; reqWData = '0;
        reqStrb = '0; reqProt = '0; ready = 1'b0; rData = '0; subError = 1'b0;
        step(); step();
        // Reset state: every output cleared.
        check_idle_outputs("rst");
        check("rst_addr", 64'(addr), 64'h0);
        check("rst_wdata", 64'(wData), 64'h0);
        check("rst_strb", 64'(strb), 64'h0);
        check("rst_rdata", 64'(respData), 64'h0);
        reset = 1'b0;
        step();

        // Write from requester 0 with ready tied high.
        set_req(0, 32'h4000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b010);
        ready = 1'b1;
        step();
        check("w_setup_state", 64'(dbgState), 64'd1);
        check("w_setup_sel", 64'(selectors), 64'b0010);
        check("w_setup_en", 64'(enable), 64'd0);
        check("w_setup_addr", 64'(addr), 64'h4000_0010);
        check("w_setup_wdata", 64'(wData), 64'hDEAD_BEEF);
        check("w_setup_strb", 64'(strb), 64'hF);
        check("w_setup_prot", 64'(prot), 64'b010);
        check("w_setup_write", 64'(write), 64'd1);
        step();
        check("w_access_en", 64'(enable), 64'd1);
        check("w_access_sel", 64'(selectors), 64'b0010);
        check("w_access_ack", 64'(reqAck), 64'h0);
        step();
        check("w_ack", 64'(reqAck), 64'b01);
        check("w_ack_err", 64'(respError), 64'd0);
        check("w_ack_state", 64'(dbgState), 64'd0);
        reqValid[0] = 1'b0;
        step();
        check_idle_outputs("w_idle");
        check("w_idle_addr_hold", 64'(addr), 64'h4000_0010);

        // Read from requester 1 with three wait cycles.
        set_req(1, 32'h8000_0020, 1'b0, 32'h0, 4'hF, 3'b101);
        ready = 1'b0;
        step();
        check("r_setup_sel", 64'(selectors), 64'b0100);
        check("r_setup_strb", 64'(strb), 64'h0);
        step();
        // A change after grant must not leak into the transfer.
        reqAddr[63:32] = 32'h0000_0000;
        for (int i = 0; i < 3; i++) begin
            check("r_wait_en", 64'(enable), 64'd1);
            check("r_wait_addr", 64'(addr), 64'h8000_0020);
            check("r_wait_sel", 64'(selectors), 64'b0100);
            check("r_wait_write", 64'(write), 64'd0);
            check("r_wait_strb", 64'(strb), 64'h0);
            check("r_wait_prot", 64'(prot), 64'b101);
            check("r_wait_ack", 64'(reqAck), 64'h0);
            step();
        end
        ready = 1'b1; rData = 32'h1234_5678;
        step();
        check("r_ack", 64'(reqAck), 64'b10);
        check("r_ack_data", 64'(respData), 64'h1234_5678);
        check("r_ack_err", 64'(respError), 64'd0);
        reqValid[1] = 1'b0; rData = 32'h0;
        step();
        check("r_hold_data", 64'(respData), 64'h1234_5678);
        check("r_hold_ack", 64'(reqAck), 64'h0);

        // Read with slave error, requester 0 (last grant was 1).
        set_req(0, 32'h0000_0004, 1'b0, 32'h0, 4'hF, 3'b000);
        subError = 1'b1; rData = 32'hCAFE_F00D;
        step();
        check("e_setup_sel", 64'(selectors), 64'b0001);
        check("e_setup_strb", 64'(strb), 64'h0);
        step();
        step();
        check("e_ack", 64'(reqAck), 64'b01);
        check("e_ack_err", 64'(respError), 64'd1);
        check("e_ack_data", 64'(respData), 64'hCAFE_F00D);
        reqValid[0] = 1'b0; subError = 1'b0;
        step();
        check("e_after_err", 64'(respError), 64'd0);
        check("e_after_data", 64'(respData), 64'hCAFE_F00D);

        // Back-to-back round-robin with both requesters held high.
        reset = 1'b1; step(); reset = 1'b0;
        set_req(0, 32'hC000_0000, 1'b1, 32'hAAAA_0000, 4'h3, 3'b001);
        set_req(1, 32'h4000_0004, 1'b1, 32'hBBBB_0000, 4'hC, 3'b011);
        ready = 1'b1;
        step();
        check("rr_g0_state", 64'(dbgState), 64'd1);
        check("rr_g0_addr", 64'(addr), 64'hC000_0000);
        check("rr_g0_sel", 64'(selectors), 64'b1000);
        step();
        step();
        check("rr_ack0", 64'(reqAck), 64'b01);
        check("rr_g1_state", 64'(dbgState), 64'd1);
        check("rr_g1_addr", 64'(addr), 64'h4000_0004);
        check("rr_g1_strb", 64'(strb), 64'hC);
        step();
        step();
        check("rr_ack1", 64'(reqAck), 64'b10);
        check("rr_g2_state", 64'(dbgState), 64'd1);
        check("rr_g2_addr", 64'(addr), 64'hC000_0000);
        step();
        step();
        check("rr_ack2", 64'(reqAck), 64'b01);
        check("rr_g3_state", 64'(dbgState), 64'd1);
        check("rr_g3_addr", 64'(addr), 64'h4000_0004);
        step();
        step();
        check("rr_ack3", 64'(reqAck), 64'b10);
        check("rr_g4_state", 64'(dbgState), 64'd1);
        check("rr_g4_addr", 64'(addr), 64'hC000_0000);
        reqValid = '0;
        ready = 1'b0;

        // Reset in the middle of ACCESS aborts with no ack.
        step();
        check("ra_access_en", 64'(enable), 64'd1);
        reset = 1'b1;
        step();
        check_idle_outputs("ra");
        check("ra_addr", 64'(addr), 64'h0);
        check("ra_prot", 64'(prot), 64'h0);
        check("ra_write", 64'(write), 64'd0);
        check("ra_wdata", 64'(wData), 64'h0);
        check("ra_strb", 64'(strb), 64'h0);
        check("ra_rdata", 64'(respData), 64'h0);
        reset = 1'b0; ready = 1'b1;
        step();
        check("ra_no_ack", 64'(reqAck), 64'h0);
        check("ra_stay_idle", 64'(dbgState), 64'd0);

        // Stalled slave: ready held low.
        ready = 1'b0; rData = 32'h5555_5555;
        set_req(1, 32'h0000_0100, 1'b0, 32'h0, 4'h0, 3'b000);
        step();
        step();
        check("to_access", 64'(dbgState), 64'd2);
`ifdef APB_RR_TIMEOUT_EN
        seen = 0;
        for (int i = 1; i <= 40 && seen == 0; i++) begin
            step();
            if (reqAck != 2'b00) seen = i;
        end
        check("to_cycles", 64'(seen), 64'd16);
        check("to_ack", 64'(reqAck), 64'b10);
        check("to_err", 64'(respError), 64'd1);
        check("to_data", 64'(respData), 64'h0);
        check("to_sel", 64'(selectors), 64'h0);
        check("to_en", 64'(enable), 64'd0);
        reqValid = '0;
`else
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (reqAck != 2'b00) seen++;
        end
        check("to_no_ack", 64'(seen), 64'd0);
        check("to_still_access", 64'(dbgState), 64'd2);
        check("to_still_en", 64'(enable), 64'd1);
        reqValid = '0;
        reset = 1'b1; step(); reset = 1'b0;
`endif
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
